// File: rtl/neander_arb_pkg.sv
// Shared types and constants for the NEANDER-X memory arbiter.
// The owner encoding also appears on the owner output port.
package neander_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    CPU_BUSY = 2'b01,
    LDR_BUSY = 2'b10
  } arb_state_t;

  localparam logic [1:0] OWN_IDLE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_LDR  = 2'b10;

  // Read data returned to a requester whose transfer was aborted by the watchdog
  localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

  // Map an arbiter state onto the externally visible owner code
  function automatic logic [1:0] owner_of(input arb_state_t st);
    logic [1:0] own;
    case (st)
      CPU_BUSY: own = OWN_CPU;
      LDR_BUSY: own = OWN_LDR;
      IDLE:     own = OWN_IDLE;
      default:  own = OWN_IDLE;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/neander_arb_watchdog.sv
// Busy-cycle watchdog for the memory arbiter.
// Counts enabled cycles since the last clear and raises timeout_pulse
// (combinationally) on the cycle whose count equals TIMEOUT_CYCLES-1.
// TIMEOUT_CYCLES = 0 removes the counter and ties the pulse low.
module neander_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_WIDTH       = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout_pulse
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign timeout_pulse = 1'b0;
    end else begin : g_on
      localparam logic [TO_WIDTH-1:0] LIMIT = TO_WIDTH'(TIMEOUT_CYCLES - 1);
      localparam logic [TO_WIDTH-1:0] ONE   = TO_WIDTH'(1);

      logic [TO_WIDTH-1:0] count_r;

      // Busy-cycle counter: clear wins over increment so a new grant starts at zero
      always_ff @(posedge clk) begin
        if (reset) begin
          count_r <= '0;
        end else if (clear) begin
          count_r <= '0;
        end else if (enable) begin
          count_r <= count_r + ONE;
        end
      end

      assign timeout_pulse = enable && (count_r == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/neander_mem_arbiter.sv
// Two-requester arbiter in front of the SPI memory controller handshake.
// The CPU and the program-loader/debug port share one mem_req/mem_ready
// channel; the winner's command is registered and held for the whole
// transfer, and ready/read data are routed back to the granted requester.
// Optional build macro ARB_ROUND_ROBIN_EN: simultaneous requests go to the
// requester not served last instead of following LDR_PRIORITY.
module neander_mem_arbiter
  import neander_arb_pkg::*;
#(
  parameter int LDR_PRIORITY   = 1,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_WIDTH       = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic        cpu_req,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  input  logic [15:0] ldr_addr,
  input  logic [7:0]  ldr_wdata,
  input  logic        ldr_write,
  input  logic        ldr_req,
  output logic [7:0]  ldr_rdata,
  output logic        ldr_ready,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data_out,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_req,
  input  logic [7:0]  mem_data_in,
  input  logic        mem_ready,
  output logic [1:0]  owner,
  output logic        err_timeout
);

  arb_state_t  state_r;
  arb_state_t  state_next_s;
  logic        ldr_wins_s;
  logic        grant_cpu_s;
  logic        grant_ldr_s;
  logic        busy_s;
  logic        finish_s;
  logic        wd_pulse_s;
  logic        timeout_s;
  logic        cpu_cmd_read_s;

  logic [15:0] mem_addr_r;
  logic [7:0]  mem_data_out_r;
  logic        mem_read_r;
  logic        mem_write_r;
  logic        mem_req_r;
  logic [1:0]  owner_r;
  logic        err_timeout_r;

`ifdef ARB_ROUND_ROBIN_EN
  // 0 = CPU was served last, 1 = loader was served last
  logic        last_owner_r;
`endif

  assign busy_s    = (state_r == CPU_BUSY) || (state_r == LDR_BUSY);
  // A real completion always beats a coinciding watchdog expiry
  assign timeout_s = wd_pulse_s && !mem_ready;
  assign finish_s  = busy_s && (mem_ready || timeout_s);

  // CPU command normalisation: write dominates, no strobe at all means read
  always_comb begin
    cpu_cmd_read_s = 1'b0;
    if (cpu_write) begin
      cpu_cmd_read_s = 1'b0;
    end else if (cpu_read) begin
      cpu_cmd_read_s = 1'b1;
    end else begin
      cpu_cmd_read_s = 1'b1;
    end
  end

  // Tie-break for simultaneous requests
  always_comb begin
    ldr_wins_s = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    if (last_owner_r == 1'b0) begin
      ldr_wins_s = 1'b1;
    end else begin
      ldr_wins_s = 1'b0;
    end
`else
    if (LDR_PRIORITY != 0) begin
      ldr_wins_s = 1'b1;
    end else begin
      ldr_wins_s = 1'b0;
    end
`endif
  end

  // Next-state and grant decode; arbitration happens only in IDLE
  always_comb begin
    state_next_s = state_r;
    grant_cpu_s  = 1'b0;
    grant_ldr_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (cpu_req && ldr_req) begin
          if (ldr_wins_s) begin
            grant_ldr_s  = 1'b1;
            state_next_s = LDR_BUSY;
          end else begin
            grant_cpu_s  = 1'b1;
            state_next_s = CPU_BUSY;
          end
        end else if (cpu_req) begin
          grant_cpu_s  = 1'b1;
          state_next_s = CPU_BUSY;
        end else if (ldr_req) begin
          grant_ldr_s  = 1'b1;
          state_next_s = LDR_BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      CPU_BUSY, LDR_BUSY: begin
        if (finish_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, owner and sticky error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      owner_r       <= OWN_IDLE;
      err_timeout_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      owner_r <= owner_of(state_next_s);
      if (timeout_s) begin
        err_timeout_r <= 1'b1;
      end
    end
  end

  // Registered command to the SPI controller: loaded on grant, held while busy, cleared on completion
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr_r     <= 16'h0000;
      mem_data_out_r <= 8'h00;
      mem_read_r     <= 1'b0;
      mem_write_r    <= 1'b0;
      mem_req_r      <= 1'b0;
    end else if (grant_cpu_s) begin
      mem_addr_r     <= cpu_addr;
      mem_data_out_r <= cpu_wdata;
      mem_read_r     <= cpu_cmd_read_s;
      mem_write_r    <= cpu_write;
      mem_req_r      <= 1'b1;
    end else if (grant_ldr_s) begin
      mem_addr_r     <= ldr_addr;
      mem_data_out_r <= ldr_wdata;
      mem_read_r     <= !ldr_write;
      mem_write_r    <= ldr_write;
      mem_req_r      <= 1'b1;
    end else if (finish_s) begin
      mem_addr_r     <= 16'h0000;
      mem_data_out_r <= 8'h00;
      mem_read_r     <= 1'b0;
      mem_write_r    <= 1'b0;
      mem_req_r      <= 1'b0;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember who was granted last so the other side wins the next tie
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_r <= 1'b0;
    end else if (grant_ldr_s) begin
      last_owner_r <= 1'b1;
    end else if (grant_cpu_s) begin
      last_owner_r <= 1'b0;
    end
  end
`endif

  // Completion routing: ready strobes only to the current owner, 0xFF data on watchdog abort
  always_comb begin
    cpu_ready = 1'b0;
    ldr_ready = 1'b0;
    cpu_rdata = mem_data_in;
    ldr_rdata = mem_data_in;
    if (state_r == CPU_BUSY) begin
      cpu_ready = mem_ready || timeout_s;
      if (timeout_s) begin
        cpu_rdata = TIMEOUT_RDATA;
      end else begin
        cpu_rdata = mem_data_in;
      end
    end else if (state_r == LDR_BUSY) begin
      ldr_ready = mem_ready || timeout_s;
      if (timeout_s) begin
        ldr_rdata = TIMEOUT_RDATA;
      end else begin
        ldr_rdata = mem_data_in;
      end
    end else begin
      cpu_ready = 1'b0;
      ldr_ready = 1'b0;
    end
  end

  neander_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_WIDTH      (TO_WIDTH)
  ) u_watchdog (
    .clk          (clk),
    .reset        (reset),
    .clear        (grant_cpu_s || grant_ldr_s || finish_s),
    .enable       (busy_s),
    .timeout_pulse(wd_pulse_s)
  );

  assign mem_addr     = mem_addr_r;
  assign mem_data_out = mem_data_out_r;
  assign mem_read     = mem_read_r;
  assign mem_write    = mem_write_r;
  assign mem_req      = mem_req_r;
  assign owner        = owner_r;
  assign err_timeout  = err_timeout_r;

endmodule

// File: tb/tb_neander_mem_arbiter.sv
// Self-checking bench for neander_mem_arbiter (TIMEOUT_CYCLES = 16).
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_neander_mem_arbiter;

  localparam int TO   = 16;
  localparam int LPRI = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_read, cpu_write, cpu_req;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic [15:0] ldr_addr;
  logic [7:0]  ldr_wdata;
  logic        ldr_write, ldr_req;
  logic [7:0]  ldr_rdata;
  logic        ldr_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_out;
  logic        mem_read, mem_write, mem_req;
  logic [7:0]  mem_data_in;
  logic        mem_ready;
  logic [1:0]  owner;
  logic        err_timeout;

  int errors = 0;
  int checks = 0;
  bit model_last_ldr = 1'b0;
  bit exp_err = 1'b0;

  neander_mem_arbiter #(
    .LDR_PRIORITY  (LPRI),
    .TIMEOUT_CYCLES(TO),
    .TO_WIDTH      (5)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_read(cpu_read),
    .cpu_write(cpu_write), .cpu_req(cpu_req), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready),
    .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_write(ldr_write),
    .ldr_req(ldr_req), .ldr_rdata(ldr_rdata), .ldr_ready(ldr_ready),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_read(mem_read),
    .mem_write(mem_write), .mem_req(mem_req), .mem_data_in(mem_data_in),
    .mem_ready(mem_ready), .owner(owner), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration rule for who gets a grant out of IDLE
  function automatic bit pick_ldr(input bit c, input bit l);
    if (c && l) begin
`ifdef ARB_ROUND_ROBIN_EN
      return !model_last_ldr;
`else
      return (LPRI != 0);
`endif
    end
    return l;
  endfunction

  task automatic check_idle(input string where);
    chk({where, ":mem_req"}, mem_req, 1'b0);
    chk({where, ":owner"}, owner, 2'b00);
    chk({where, ":cpu_ready"}, cpu_ready, 1'b0);
    chk({where, ":ldr_ready"}, ldr_ready, 1'b0);
    chk({where, ":mem_rdwr"}, {mem_read, mem_write}, 2'b00);
    chk({where, ":mem_addr"}, mem_addr, 16'h0000);
    chk({where, ":err"}, err_timeout, exp_err);
  endtask

  // Raise request(s) from an idle arbiter; a stray mem_ready may be present and must be ignored
  task automatic request(input bit c, input bit l);
    tick();
    mem_ready = 1'($urandom_range(0, 1));
    if (c) cpu_req = 1'b1;
    if (l) ldr_req = 1'b1;
    @(negedge clk);
    check_idle("req_cycle");
  endtask

  // Act as the SPI controller for one granted transfer and check everything the arbiter shows
  task automatic serve(input bit is_ldr, input int lat, input bit to_mode,
                       input logic [7:0] rdata, input int inject_at,
                       input bit drop_cpu, input bit drop_ldr);
    logic [15:0] e_addr;
    logic [7:0]  e_wd;
    bit          e_rd, e_wr;
    logic [1:0]  e_own;
    logic [7:0]  e_rdata;
    if (is_ldr) begin
      e_addr = ldr_addr; e_wd = ldr_wdata; e_wr = ldr_write; e_rd = !ldr_write; e_own = 2'b10;
    end else begin
      e_addr = cpu_addr; e_wd = cpu_wdata; e_wr = cpu_write; e_rd = !cpu_write; e_own = 2'b01;
    end
    e_rdata = to_mode ? 8'hFF : rdata;
    model_last_ldr = is_ldr;
    for (int i = 1; i <= lat; i++) begin
      tick();
      mem_ready   = (!to_mode && i == lat);
      mem_data_in = (i == lat) ? rdata : 8'($urandom);
      if (i == inject_at) cpu_req = 1'b1;
      @(negedge clk);
      chk("busy:mem_req", mem_req, 1'b1);
      chk("busy:owner", owner, e_own);
      chk("busy:mem_addr", mem_addr, e_addr);
      chk("busy:mem_data_out", mem_data_out, e_wd);
      chk("busy:mem_read", mem_read, e_rd);
      chk("busy:mem_write", mem_write, e_wr);
      chk("busy:err", err_timeout, exp_err);
      if (i == lat) begin
        chk("done:own_ready", is_ldr ? ldr_ready : cpu_ready, 1'b1);
        chk("done:other_ready", is_ldr ? cpu_ready : ldr_ready, 1'b0);
        chk("done:rdata", is_ldr ? ldr_rdata : cpu_rdata, e_rdata);
      end else begin
        chk("busy:readies", {cpu_ready, ldr_ready}, 2'b00);
      end
    end
    if (to_mode) exp_err = 1'b1;
    tick();
    mem_ready = 1'b0;
    if (drop_cpu) cpu_req = 1'b0;
    if (drop_ldr) ldr_req = 1'b0;
    @(negedge clk);
    check_idle("after_done");
  endtask

  initial begin
    bit w, c, l;
    reset = 1'b1;
    cpu_addr = 16'h0; cpu_wdata = 8'h0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_req = 1'b0;
    ldr_addr = 16'h0; ldr_wdata = 8'h0; ldr_write = 1'b0; ldr_req = 1'b0;
    mem_data_in = 8'h0; mem_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_idle("reset");
    tick();
    reset = 1'b0;

    // CPU read of 0x1234, data 0xA5 after 5 busy cycles
    cpu_addr = 16'h1234; cpu_read = 1'b1; cpu_write = 1'b0;
    request(1'b1, 1'b0);
    serve(1'b0, 5, 1'b0, 8'hA5, 0, 1'b1, 1'b0);

    // Simultaneous requests: arbitration winner first, the other on the following IDLE cycle
    cpu_addr = 16'h0040; cpu_wdata = 8'h11; cpu_read = 1'b1; cpu_write = 1'b1;
    ldr_addr = 16'h8001; ldr_wdata = 8'h22; ldr_write = 1'b0;
    w = pick_ldr(1'b1, 1'b1);
    request(1'b1, 1'b1);
    serve(w, 3, 1'b0, 8'h5C, 0, !w, w);
    serve(!w, 4, 1'b0, 8'hC3, 0, w, !w);

    // Loader write 0x0200 <- 0x3C with the CPU arriving mid-transfer with different inputs
    ldr_addr = 16'h0200; ldr_wdata = 8'h3C; ldr_write = 1'b1;
    cpu_addr = 16'hBEEF; cpu_wdata = 8'h99; cpu_read = 1'b0; cpu_write = 1'b0;
    request(1'b0, 1'b1);
    serve(1'b1, 6, 1'b0, 8'h00, 2, 1'b0, 1'b1);
    serve(1'b0, 2, 1'b0, 8'h7E, 0, 1'b1, 1'b0);

    // mem_ready lands on the very cycle the watchdog would fire: normal completion
    cpu_addr = 16'h00FF; cpu_read = 1'b1;
    request(1'b1, 1'b0);
    serve(1'b0, TO, 1'b0, 8'h5A, 0, 1'b1, 1'b0);

    // Controller never answers: abort on busy cycle 16 with 0xFF, sticky error
    ldr_addr = 16'h4321; ldr_write = 1'b0;
    request(1'b0, 1'b1);
    serve(1'b1, TO, 1'b1, 8'h00, 0, 1'b0, 1'b1);
    cpu_addr = 16'h0A0A; cpu_wdata = 8'h44; cpu_write = 1'b1;
    request(1'b1, 1'b0);
    serve(1'b0, 3, 1'b0, 8'h12, 0, 1'b1, 1'b0);

    // Reset on the 3rd busy cycle: back to idle, no ready, error cleared
    cpu_addr = 16'h7777; cpu_write = 1'b0;
    request(1'b1, 1'b0);
    tick(); mem_ready = 1'b0;
    tick();
    tick(); reset = 1'b1;
    @(negedge clk);
    chk("rst_mid:err_before", err_timeout, 1'b1);
    chk("rst_mid:cpu_ready", cpu_ready, 1'b0);
    tick(); reset = 1'b0; cpu_req = 1'b0;
    exp_err = 1'b0; model_last_ldr = 1'b0;
    @(negedge clk);
    check_idle("rst_mid");

    // Both requesters held continuously across four grants
    cpu_addr = 16'h1000; cpu_wdata = 8'hAA; cpu_read = 1'b0; cpu_write = 1'b1;
    ldr_addr = 16'h2000; ldr_wdata = 8'hBB; ldr_write = 1'b1;
    request(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      w = pick_ldr(1'b1, 1'b1);
      serve(w, 2, 1'b0, 8'h00, 0, k == 3, k == 3);
    end

    // Randomized transactions against the reference rules
    for (int n = 0; n < 24; n++) begin
      c = 1'($urandom_range(0, 1));
      l = c ? 1'($urandom_range(0, 1)) : 1'b1;
      cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
      cpu_read = 1'($urandom_range(0, 1)); cpu_write = 1'($urandom_range(0, 1));
      ldr_addr = 16'($urandom); ldr_wdata = 8'($urandom);
      ldr_write = 1'($urandom_range(0, 1));
      w = pick_ldr(c, l);
      request(c, l);
      serve(w, $urandom_range(1, 12), 1'b0, 8'($urandom), 0, !w, w);
      if (c && l) begin
        serve(!w, $urandom_range(1, 12), 1'b0, 8'($urandom), 0, w, !w);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neander_mem_arbiter.md
Name: neander_mem_arbiter

Overview:
- Shares the single SPI memory controller handshake (mem_req/mem_ready, 16-bit address, 8-bit data) between two requesters: the NEANDER-X CPU and a program-loader/debug port.
- Sits between cpu_top and the SPI memory controller. Grants one requester at a time, holds a registered command stable for the whole transfer, and routes the ready strobe and read data back to the granted requester.
- A watchdog aborts transfers the controller never completes.

Parameters:
- LDR_PRIORITY, 1, 1 = loader wins simultaneous requests; 0 = CPU wins.
- TIMEOUT_CYCLES, 4096, busy cycles without mem_ready before abort; 0 disables the watchdog.
- TO_WIDTH, 13, timeout counter width; must satisfy 2^TO_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_read  in  1  CPU read strobe (level).
- cpu_write  in  1  CPU write strobe (level).
- cpu_req  in  1  CPU request, held until cpu_ready.
- cpu_rdata  out  8  read data to CPU.
- cpu_ready  out  1  one-cycle completion strobe to CPU.
- ldr_addr  in  16  loader address.
- ldr_wdata  in  8  loader write data.
- ldr_write  in  1  loader write (0 = read).
- ldr_req  in  1  loader request, held until ldr_ready.
- ldr_rdata  out  8  read data to loader.
- ldr_ready  out  1  one-cycle completion strobe to loader.
- mem_addr  out  16  address to SPI controller.
- mem_data_out  out  8  write data to SPI controller.
- mem_read  out  1  read command.
- mem_write  out  1  write command.
- mem_req  out  1  request to SPI controller.
- mem_data_in  in  8  read data from SPI controller.
- mem_ready  in  1  completion strobe from SPI controller.
- owner  out  2  00 idle, 01 CPU, 10 loader.
- err_timeout  out  1  sticky watchdog flag.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE; all mem_* outputs 0; owner 00; err_timeout 0; timeout counter 0.
- Reset mid-transfer: state returns to IDLE at the next edge and mem_req drops with no ready strobe. The SPI controller shares the same reset.
- States:
  - IDLE → CPU_BUSY when cpu_req and the CPU wins arbitration.
  - IDLE → LDR_BUSY when ldr_req and the loader wins.
  - *_BUSY → IDLE on mem_ready or on timeout.
- Arbitration: evaluated only in IDLE. Simultaneous requests go to the requester selected by LDR_PRIORITY. A request arriving during BUSY waits; it is never dropped.
- Grant edge: register addr/wdata/read/write from the winner. mem_req = 1 from the cycle after the request is seen in IDLE.
- Command normalisation:
  - CPU: write has priority if cpu_read and cpu_write are both set; neither set is treated as a read.
  - Loader: mem_read = !ldr_write.
- mem_* outputs stay constant for the entire busy period.
- Completion:
  - cpu_ready = mem_ready && CPU_BUSY, combinational; cpu_rdata = mem_data_in, pass-through. Loader side identical.
  - Non-granted ready outputs stay 0.
  - On completion all mem_* outputs clear to 0 next edge and the arbiter spends at least one IDLE cycle. A back-to-back request is granted on that IDLE cycle.
- mem_ready while IDLE is ignored.
- Watchdog: the counter clears on grant and increments each busy cycle. When count == TIMEOUT_CYCLES-1 with no mem_ready:
  - pulse the owner's ready with rdata = 8'hFF;
  - set err_timeout; go to IDLE.
  - err_timeout clears only on reset.
  - If mem_ready and timeout coincide, mem_ready wins: normal completion, no error.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last_owner register (reset = CPU) replaces LDR_PRIORITY for simultaneous requests. The requester not served last wins, and the parameter is ignored.
- Undefined: fixed priority per LDR_PRIORITY; no last_owner register.

Decomposition:
- Package neander_arb_pkg:
  - arb_state_t enum (IDLE, CPU_BUSY, LDR_BUSY);
  - owner encoding constants OWN_IDLE / OWN_CPU / OWN_LDR;
  - TIMEOUT_RDATA = 8'hFF.
- Sub-module neander_arb_watchdog: counter with clear/enable inputs and a timeout-pulse output; tied off when TIMEOUT_CYCLES = 0.

Test Plan:
- CPU read 0x1234, controller returns 0xA5 after 5 cycles → mem_req rises 1 cycle after cpu_req; mem_addr = 0x1234 held; cpu_ready pulses once with cpu_rdata = 0xA5; ldr_ready stays 0.
- cpu_req and ldr_req in the same cycle, LDR_PRIORITY = 1 → loader served first, owner = 10; CPU granted on the following IDLE cycle; both complete.
- Loader write 0x0200 ← 0x3C while cpu_req rises mid-transfer → mem_data_out stays 0x3C and mem_write stays 1 until mem_ready; CPU then granted.
- TIMEOUT_CYCLES = 16 and mem_ready never asserted → ready pulses on busy cycle 16 with rdata = 0xFF; err_timeout = 1 until reset.
- reset asserted on the 3rd busy cycle → next edge: mem_req = 0, owner = 00, no ready pulse.
- With ARB_ROUND_ROBIN_EN, both requesters held continuously → grants alternate LDR, CPU, LDR, CPU…
